sram22_march_bist: RTL and testbench
====================================

Name: sram22_march_bist

Overview:
- Built-in self-test controller that drives a single-port SRAM22 macro (clk/we/addr/din/dout, 1-cycle registered read, dout undefined after a write).
- Runs a March C- sequence over every address and compares each read one cycle after issue.
- Reports pass, or the first failing address, element and read data.
- Sits between the macro and the chip test/scan logic; it is the initiator on the macro's port.

Parameters:
- DATA_WIDTH, 8, SRAM word width.
- ADDR_WIDTH, 12, SRAM address width; N = 1 << ADDR_WIDTH words.

Ports:
- clk  input  1  clock; same clock as the SRAM macro.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only when busy=0.
- bg  input  DATA_WIDTH  background pattern; "0" = bg, "1" = ~bg; sampled with start.
- busy  output  1  run in progress.
- done  output  1  run finished; held until next accepted start or rst.
- pass  output  1  valid while done=1; 1 = no mismatch.
- fail_addr  output  ADDR_WIDTH  address of first mismatch.
- fail_elem  output  3  March element index (0..5) of first mismatch.
- fail_data  output  DATA_WIDTH  data actually read at first mismatch.
- sram_we  output  1  to macro we.
- sram_addr  output  ADDR_WIDTH  to macro addr.
- sram_din  output  DATA_WIDTH  to macro din.
- sram_dout  input  DATA_WIDTH  from macro dout.

Behaviour:
- Reset: all outputs 0 (busy, done, pass, fail_*, sram_we, sram_addr, sram_din). Reset takes effect the cycle after rst=1, including mid-run; no further SRAM writes are issued.
- March C- elements (U = addr 0 to N-1, D = addr N-1 to 0):
  - E0 U(w0)
  - E1 U(r0,w1)
  - E2 U(r1,w0)
  - E3 D(r0,w1)
  - E4 D(r1,w0)
  - E5 U(r0)
- Ops: one SRAM op per cycle.
  - Read: sram_we=0, sram_din=0.
  - Write: sram_we=1, sram_din=bg or ~bg.
  - In E1-E4, each address takes two consecutive cycles: read, then write to the same address.
- Compare: a read issued in cycle t is compared against its expected value in cycle t+1 (registered pending flag plus expected value). Cycles following a write are never compared.
- Timing: start accepted in cycle 0.
  - Cycle 1: busy=1, first E0 write at addr 0.
  - E0 occupies cycles 1..N; E1-E4 occupy N+1..9N; E5 occupies 9N+1..10N.
  - Drain compare in cycle 10N+1.
  - Cycle 10N+2: done=1, pass=1, busy=0, sram_we=0.
- Element boundaries: the address counter wraps to 0 (U) or N-1 (D) with no idle cycle between elements.
- Mismatch detected in cycle c:
  - Latch fail_addr, fail_elem, fail_data from the compared read.
  - The op issued in cycle c still completes; no op is issued after it.
  - Cycle c+1: done=1, pass=0, busy=0.
  - Only the first mismatch is recorded.
- start handling:
  - Ignored while busy=1.
  - start with done=1 clears done, pass and fail_* next cycle and begins a new run.
- FSM states: IDLE, RUN (element index, address counter, rd/wr phase), DRAIN, DONE.

Decomposition:
- Package sram22_bist_pkg holds:
  - March element enum E0..E5 and NUM_ELEM=6.
  - Per-element table: direction, has_read, read_expects_inv, has_write, write_inv.
  - Op-phase enum: RD, WR.
- Sub-module sram22_march_addr_gen: up/down address counter with load, step, direction and last-address flag.

Test Plan (ADDR_WIDTH=3, DATA_WIDTH=8, N=8; bench uses a behavioural 1-cycle-read SRAM with fault injection):
- rst held 2 cycles -> every output is 0; sram_we stays 0 while idle.
- Fault-free, bg=8'h00, start pulse -> done rises exactly 82 cycles after the start cycle, pass=1; exactly 40 write cycles and 40 read cycles observed; sram_addr order in E3 is 7,7,6,6,...,0,0.
- Bit0 of addr 5 stuck at 1 -> done with pass=0, fail_elem=1, fail_addr=5, fail_data=8'h01; no SRAM op after the mismatch cycle's op.
- Address-decoder fault (writes to addr 6 also write addr 2), bg=8'h00 -> pass=0, fail_elem=3, fail_addr=2, fail_data=8'hFF.
- Fault-free, bg=8'hA5 -> E0 writes 8'hA5, E1 writes 8'h5A; pass=1. Second start while busy is ignored; start after done reruns and passes.
- rst asserted in the middle of E2 -> outputs 0 next cycle, no writes afterwards. A new start then completes with pass=1 in 82 cycles.

Source files
------------

// File: rtl/sram22_bist_pkg.sv
// Shared types for the SRAM22 March C- BIST: element and phase enums,
// FSM state encoding and the per-element March table.
package sram22_bist_pkg;

    localparam int unsigned NUM_ELEM = 6;
    localparam int unsigned ELEM_W   = 3;

    typedef enum logic [ELEM_W-1:0] {
        E0 = 3'd0,
        E1 = 3'd1,
        E2 = 3'd2,
        E3 = 3'd3,
        E4 = 3'd4,
        E5 = 3'd5
    } elem_e;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } phase_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bist_state_e;

    // One March element: address direction, optional read (and its expected
    // polarity), optional write (and its polarity). "inv" selects ~bg.
    typedef struct packed {
        logic down;
        logic has_read;
        logic read_inv;
        logic has_write;
        logic write_inv;
    } elem_cfg_t;

    // March C-: U(w0) U(r0,w1) U(r1,w0) D(r0,w1) D(r1,w0) U(r0)
    localparam elem_cfg_t ELEM_TAB [NUM_ELEM] = '{
        '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
        '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},
        '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
        '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
        '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
        '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0}
    };

endpackage

// File: rtl/sram22_march_bist_if.sv
// SRAM22 macro port as seen by the BIST.
//   master: BIST side (drives sram_we/sram_addr/sram_din, receives sram_dout)
//   slave : macro side
interface sram22_march_bist_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 12
);
    logic                  sram_we;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_din;
    logic [DATA_WIDTH-1:0] sram_dout;

    modport master (
        output sram_we,
        output sram_addr,
        output sram_din,
        input  sram_dout
    );

    modport slave (
        input  sram_we,
        input  sram_addr,
        input  sram_din,
        output sram_dout
    );
endinterface

// File: rtl/sram22_march_addr_gen.sv
// Up/down address counter for the March sequencer.
//   load/load_down : restart at 0 (up) or N-1 (down) and latch direction
//   step           : advance one address in the latched direction
//   addr           : current address (registered)
//   last_c         : addr is the final address for the latched direction
module sram22_march_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  load_down,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last_c
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  down_q;

    // Counter and direction register
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            down_q <= 1'b0;
        end else if (load) begin
            addr_q <= load_down ? ADDR_MAX : '0;
            down_q <= load_down;
        end else if (step) begin
            addr_q <= down_q ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
        end
    end

    assign addr   = addr_q;
    assign last_c = down_q ? (addr_q == '0) : (addr_q == ADDR_MAX);

endmodule

// File: rtl/sram22_march_bist.sv
// March C- built-in self-test controller for a single-port SRAM22 macro.
//   clk, rst         : macro clock; synchronous active-high reset
//   start, bg        : begin a run with background bg (sampled when not busy)
//   busy, done, pass : run status; pass valid while done
//   fail_addr/elem/data : first mismatching read
//   sram             : macro port (we/addr/din out, dout in, 1-cycle read)
module sram22_march_bist
    import sram22_bist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] bg,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [ELEM_W-1:0]     fail_elem,
    output logic [DATA_WIDTH-1:0] fail_data,
    sram22_march_bist_if.master   sram
);

    bist_state_e           st_q, st_d;
    elem_e                 elem_q, elem_d, elem_nx;
    phase_e                phase_q, phase_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    elem_e                 fail_elem_q, fail_elem_d;
    logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
    logic [DATA_WIDTH-1:0] bg_q, bg_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
    elem_e                 cmp_elem_q, cmp_elem_d;

    logic                  ag_load, ag_load_down, ag_step, ag_last_c;
    logic [ADDR_WIDTH-1:0] ag_addr;
    logic                  mismatch_c;

    sram22_march_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .addr      (ag_addr),
        .last_c    (ag_last_c)
    );

    // Read issued last cycle returns its data now
    assign mismatch_c = pend_q && (sram.sram_dout != exp_q);

    // Element following the current one (saturates so the table index stays valid)
    assign elem_nx = (elem_q == E5) ? E5 : elem_e'(elem_q + 3'd1);

    // Next state, next op and result capture
    always_comb begin
        st_d         = st_q;
        elem_d       = elem_q;
        phase_d      = phase_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_addr_d  = fail_addr_q;
        fail_elem_d  = fail_elem_q;
        fail_data_d  = fail_data_q;
        bg_d         = bg_q;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;

        // Remember the op presented this cycle so it can be checked next cycle
        pend_d     = (st_q == RUN) && (phase_q == RD) && !mismatch_c;
        exp_d      = ELEM_TAB[elem_q].read_inv ? ~bg_q : bg_q;
        cmp_addr_d = ag_addr;
        cmp_elem_d = elem_q;

        case (st_q)
            IDLE, DONE: begin
                if (start) begin
                    st_d        = RUN;
                    elem_d      = E0;
                    phase_d     = WR;
                    ag_load     = 1'b1;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_elem_d = E0;
                    fail_data_d = '0;
                    bg_d        = bg;
                end
            end
            RUN: begin
                if (mismatch_c) begin
                    st_d        = DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_addr_d = cmp_addr_q;
                    fail_elem_d = cmp_elem_q;
                    fail_data_d = sram.sram_dout;
                end else if (ELEM_TAB[elem_q].has_read && ELEM_TAB[elem_q].has_write
                             && (phase_q == RD)) begin
                    // Read-then-write pairs stay on the same address
                    phase_d = WR;
                end else if (!ag_last_c) begin
                    ag_step = 1'b1;
                    phase_d = ELEM_TAB[elem_q].has_read ? RD : WR;
                end else if (elem_q == E5) begin
                    st_d = DRAIN;
                end else begin
                    // Element boundary: reload the counter with no idle cycle
                    elem_d       = elem_nx;
                    ag_load      = 1'b1;
                    ag_load_down = ELEM_TAB[elem_nx].down;
                    phase_d      = ELEM_TAB[elem_nx].has_read ? RD : WR;
                end
            end
            DRAIN: begin
                st_d   = DONE;
                busy_d = 1'b0;
                done_d = 1'b1;
                pass_d = !mismatch_c;
                if (mismatch_c) begin
                    fail_addr_d = cmp_addr_q;
                    fail_elem_d = cmp_elem_q;
                    fail_data_d = sram.sram_dout;
                end
            end
            default: st_d = IDLE;
        endcase

        // Op presented to the macro next cycle
        we_d  = (st_d == RUN) && (phase_d == WR);
        din_d = '0;
        if (we_d) begin
            din_d = ELEM_TAB[elem_d].write_inv ? ~bg_d : bg_d;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= IDLE;
            elem_q      <= E0;
            phase_q     <= RD;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= E0;
            fail_data_q <= '0;
            bg_q        <= '0;
            we_q        <= 1'b0;
            din_q       <= '0;
            pend_q      <= 1'b0;
            exp_q       <= '0;
            cmp_addr_q  <= '0;
            cmp_elem_q  <= E0;
        end else begin
            st_q        <= st_d;
            elem_q      <= elem_d;
            phase_q     <= phase_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_data_q <= fail_data_d;
            bg_q        <= bg_d;
            we_q        <= we_d;
            din_q       <= din_d;
            pend_q      <= pend_d;
            exp_q       <= exp_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_elem_q  <= cmp_elem_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_addr      = fail_addr_q;
    assign fail_elem      = fail_elem_q;
    assign fail_data      = fail_data_q;
    assign sram.sram_we   = we_q;
    assign sram.sram_addr = ag_addr;
    assign sram.sram_din  = din_q;

endmodule

// File: tb/tb_sram22_march_bist.sv
// Bench for sram22_march_bist with N=8 and a behavioural 1-cycle-read SRAM
// that can model a stuck bit or an address-decoder coupling fault.
`timescale 1ns/1ps
module tb_sram22_march_bist;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned N  = 1 << AW;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } op_t;

    typedef struct {
        logic          pass;
        logic [2:0]    elem;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            lat;
        int            nwr;
        int            nrd;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] bg;
    logic          busy, done, pass;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [DW-1:0] fail_data;

    int fault_mode = 0;   // 0 none, 1 addr5 bit0 stuck-at-1, 2 write@6 also hits 2
    int n_chk  = 0;
    int n_pass = 0;

    op_t  ops_q [$];
    res_t res_q [$];
    logic [DW-1:0] mem [N];

    sram22_march_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) sif ();

    sram22_march_bist #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bg        (bg),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem),
        .fail_data (fail_data),
        .sram      (sif)
    );

    always #5 clk = ~clk;

    // Behavioural macro; dout is garbage after a write
    always @(posedge clk) begin
        if (sif.sram_we) begin
            if (fault_mode == 1 && sif.sram_addr == AW'(5))
                mem[sif.sram_addr] <= sif.sram_din | 8'h01;
            else
                mem[sif.sram_addr] <= sif.sram_din;
            if (fault_mode == 2 && sif.sram_addr == AW'(6))
                mem[2] <= sif.sram_din;
            sif.sram_dout <= DW'($urandom);
        end else begin
            sif.sram_dout <= mem[sif.sram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"},      32'(busy),          32'd0);
        check({tag, ".done"},      32'(done),          32'd0);
        check({tag, ".pass"},      32'(pass),          32'd0);
        check({tag, ".fail_addr"}, 32'(fail_addr),     32'd0);
        check({tag, ".fail_elem"}, 32'(fail_elem),     32'd0);
        check({tag, ".fail_data"}, 32'(fail_data),     32'd0);
        check({tag, ".we"},        32'(sif.sram_we),   32'd0);
        check({tag, ".addr"},      32'(sif.sram_addr), 32'd0);
        check({tag, ".din"},       32'(sif.sram_din),  32'd0);
    endtask

    // Reference March C- op stream for background b
    task automatic build_ops(input logic [DW-1:0] b);
        op_t o;
        ops_q.delete();
        for (int a = 0; a < int'(N); a++) begin
            o = '{1'b1, AW'(a), b};
            ops_q.push_back(o);
        end
        for (int e = 1; e <= 4; e++) begin
            for (int i = 0; i < int'(N); i++) begin
                int a;
                a = (e >= 3) ? (int'(N) - 1 - i) : i;
                o = '{1'b0, AW'(a), 8'h00};
                ops_q.push_back(o);
                o = '{1'b1, AW'(a), ((e == 1) || (e == 3)) ? ~b : b};
                ops_q.push_back(o);
            end
        end
        for (int a = 0; a < int'(N); a++) begin
            o = '{1'b0, AW'(a), 8'h00};
            ops_q.push_back(o);
        end
    endtask

    task automatic expect_result(input logic p, input logic [2:0] e, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input int lat, input int nwr, input int nrd);
        res_t r;
        r.pass = p; r.elem = e; r.addr = a; r.data = d;
        r.lat = lat; r.nwr = nwr; r.nrd = nrd;
        res_q.push_back(r);
    endtask

    // Start a run, score every op against the reference stream, then the result.
    // A nonzero ignore_at pulses start (with a different bg) at that busy cycle.
    task automatic run_march(input string name, input logic [DW-1:0] bgv, input int ignore_at);
        op_t  o;
        res_t r;
        int   k = 1;
        int   nwr = 0;
        int   nrd = 0;
        bit   finished = 1'b0;
        build_ops(bgv);
        bg    = bgv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bg    = ~bgv;
        while (!finished && k <= 200) begin
            if (k == 1) begin
                check({name, ".c1.busy"},      32'(busy),      32'd1);
                check({name, ".c1.done"},      32'(done),      32'd0);
                check({name, ".c1.pass"},      32'(pass),      32'd0);
                check({name, ".c1.fail_addr"}, 32'(fail_addr), 32'd0);
                check({name, ".c1.fail_elem"}, 32'(fail_elem), 32'd0);
                check({name, ".c1.fail_data"}, 32'(fail_data), 32'd0);
            end
            if (done) begin
                finished = 1'b1;
            end else begin
                if (ops_q.size() > 0) begin
                    o = ops_q.pop_front();
                    check($sformatf("%s.op%0d.we", name, k),   32'(sif.sram_we),   32'(o.we));
                    check($sformatf("%s.op%0d.addr", name, k), 32'(sif.sram_addr), 32'(o.addr));
                    check($sformatf("%s.op%0d.din", name, k),  32'(sif.sram_din),  32'(o.din));
                end else begin
                    check($sformatf("%s.drain%0d.we", name, k), 32'(sif.sram_we), 32'd0);
                    check($sformatf("%s.drain%0d.busy", name, k), 32'(busy), 32'd1);
                end
                if (busy && sif.sram_we) nwr++;
                if (busy && !sif.sram_we && k <= int'(10 * N)) nrd++;
                if (k == ignore_at) begin
                    start = 1'b1;
                    bg    = 8'hFF;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0;
        check({name, ".done_seen"}, 32'(finished), 32'd1);
        r = res_q.pop_front();
        if (finished) begin
            check({name, ".latency"},   32'(k),         32'(r.lat));
            check({name, ".pass"},      32'(pass),      32'(r.pass));
            check({name, ".fail_elem"}, 32'(fail_elem), 32'(r.elem));
            check({name, ".fail_addr"}, 32'(fail_addr), 32'(r.addr));
            check({name, ".fail_data"}, 32'(fail_data), 32'(r.data));
            check({name, ".busy_off"},  32'(busy),      32'd0);
            check({name, ".writes"},    32'(nwr),       32'(r.nwr));
            check({name, ".reads"},     32'(nrd),       32'(r.nrd));
        end
        ops_q.delete();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s.post%0d.we", name, i),   32'(sif.sram_we), 32'd0);
            check($sformatf("%s.post%0d.done", name, i), 32'(done),        32'd1);
            @(negedge clk);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        bg    = '0;

        // Reset and idle
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("idle%0d.we", i), 32'(sif.sram_we), 32'd0);
        end

        // Fault-free, bg=00
        fault_mode = 0;
        expect_result(1'b1, 3'd0, '0, 8'h00, 82, 40, 40);
        run_march("clean00", 8'h00, 0);

        // Stuck-at-1 on bit0 of addr 5: caught by the first E1 read of addr 5
        fault_mode = 1;
        expect_result(1'b0, 3'd1, AW'(5), 8'h01, 21, 14, 6);
        run_march("stuck", 8'h00, 0);

        // Writes to 6 also land on 2: caught reading addr 2 in E3
        fault_mode = 2;
        expect_result(1'b0, 3'd3, AW'(2), 8'hFF, 53, 30, 22);
        run_march("decoder", 8'h00, 0);

        // bg=A5 with an ignored start mid-run, then a rerun from done
        fault_mode = 0;
        expect_result(1'b1, 3'd0, '0, 8'h00, 82, 40, 40);
        run_march("bgA5", 8'hA5, 30);
        expect_result(1'b1, 3'd0, '0, 8'h00, 82, 40, 40);
        run_march("bgA5_rerun", 8'hA5, 0);

        // Reset in the middle of E2 (cycles 25..40)
        bg    = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        check("midrst.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("midrst.after%0d.we", i),   32'(sif.sram_we), 32'd0);
            check($sformatf("midrst.after%0d.busy", i), 32'(busy),        32'd0);
        end

        expect_result(1'b1, 3'd0, '0, 8'h00, 82, 40, 40);
        run_march("after_rst", 8'h00, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
